pc_ctrl: RTL and testbench

- Fetch-stage program-counter controller for the 5-stage MIPS pipeline.
- Owns the PC register and selects the next PC from three sources: sequential PC+4, the branch/jump target computed in D by the NPC unit, and the jr target.
- Applies hazard-unit stalls and instruction-memory back-pressure.
- Preserves delay-slot semantics by holding a decided redirect until the delay-slot fetch is accepted.

---
 rtl/pc_ctrl_pkg.sv | 33 +++
 rtl/pc_redirect_latch.sv | 55 +++++
 rtl/pc_ctrl.sv | 111 +++++++++++
 tb/tb_pc_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types for the fetch-stage PC controller: reset vector, FSM encoding
// and the redirect-source select that the decoder also uses.
package pc_ctrl_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_J   = 2'd2,
        SEL_JR  = 2'd3
    } tgt_sel_t;

    // jr wins over j, which wins over a taken branch.
    function automatic tgt_sel_t decode_sel(input logic is_branch, input logic br_cond,
                                            input logic is_j, input logic is_jr);
        if (is_jr)
            return SEL_JR;
        else if (is_j)
            return SEL_J;
        else if (is_branch && br_cond)
            return SEL_BR;
        else
            return SEL_SEQ;
    endfunction

endpackage

// File: rtl/pc_redirect_latch.sv
// Holds a decided redirect target while the delay-slot fetch waits on the
// instruction memory, and performs the word-alignment fixup/check.
module pc_redirect_latch
    import pc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        take,
    input  logic        latch_en,
    input  logic        release_en,
    input  logic [31:0] tgt_raw,
    output logic [31:0] tgt_fix,
    output logic [31:0] pend_tgt,
    output logic        pending,
    output logic        align_err
);

    logic [31:0] pend_tgt_reg;
    logic        pending_reg;
    logic        align_err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_fix
            if (gi < 2) begin : g_low
                assign tgt_fix[gi] = 1'b0;
            end else begin : g_high
                assign tgt_fix[gi] = tgt_raw[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_tgt_reg  <= 32'd0;
            pending_reg   <= 1'b0;
            align_err_reg <= 1'b0;
        end else begin
            if (latch_en) begin
                pend_tgt_reg <= tgt_fix;
                pending_reg  <= 1'b1;
            end else if (release_en) begin
                pending_reg  <= 1'b0;
            end
            // Only redirects actually taken are checked; ignored ones in HOLD are not.
            if (take && (tgt_raw[1:0] != 2'b00))
                align_err_reg <= 1'b1;
        end
    end

    assign pend_tgt  = pend_tgt_reg;
    assign pending   = pending_reg;
    assign align_err = align_err_reg;

endmodule

// File: rtl/pc_ctrl.sv
// Fetch-stage PC controller: owns pc_F, picks sequential/branch/jump/jr next
// PC, honours stalls and imem back-pressure, and keeps delay-slot ordering.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_D,
    input  logic             is_branch_D,
    input  logic             br_cond_D,
    input  logic             is_j_D,
    input  logic             is_jr_D,
    input  logic [31:0]      npc_target_D,
    input  logic [31:0]      jr_target_D,
    input  logic             imem_ready,
    output logic [31:0]      pc_F,
    output logic [31:0]      pc4_F,
    output logic             fetch_valid,
    output logic             redirect_pending,
    output logic             align_err,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_reg;
    logic [31:0]      pc_reg;
    logic             fetch_valid_reg;
    logic [CNT_W-1:0] cnt_reg;

    tgt_sel_t    sel;
    logic        redirect_d;
    logic [31:0] tgt_raw;
    logic [31:0] tgt_fix;
    logic [31:0] pend_tgt;
    logic        accept;
    logic        take;
    logic        latch_en;
    logic        release_en;

    assign sel        = decode_sel(is_branch_D, br_cond_D, is_j_D, is_jr_D);
    assign redirect_d = !stall_D && (sel != SEL_SEQ);
    assign tgt_raw    = (sel == SEL_JR) ? jr_target_D : npc_target_D;
    assign accept     = fetch_valid_reg && imem_ready && !stall_D;

    // A redirect is only honoured in RUN; in HOLD the delay slot has not moved.
    assign take       = (state_reg == ST_RUN) && redirect_d;
    assign latch_en   = take && !accept;
    assign release_en = (state_reg == ST_HOLD) && accept;

    pc_redirect_latch u_latch (
        .clk        (clk),
        .reset      (reset),
        .take       (take),
        .latch_en   (latch_en),
        .release_en (release_en),
        .tgt_raw    (tgt_raw),
        .tgt_fix    (tgt_fix),
        .pend_tgt   (pend_tgt),
        .pending    (redirect_pending),
        .align_err  (align_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_BOOT;
            pc_reg          <= RESET_PC;
            fetch_valid_reg <= 1'b0;
            cnt_reg         <= '0;
        end else begin
            case (state_reg)
                ST_BOOT: begin
                    state_reg       <= ST_RUN;
                    fetch_valid_reg <= 1'b1;
                end
                ST_RUN: begin
                    if (take) begin
                        if (cnt_reg != CNT_MAX)
                            cnt_reg <= cnt_reg + CNT_ONE;
                        if (accept)
                            pc_reg <= tgt_fix;
                        else
                            state_reg <= ST_HOLD;
                    end else if (accept) begin
                        pc_reg <= pc_reg + 32'd4;
                    end
                end
                ST_HOLD: begin
                    if (accept) begin
                        pc_reg    <= pend_tgt;
                        state_reg <= ST_RUN;
                    end
                end
                default: begin
                    state_reg       <= ST_BOOT;
                    fetch_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign pc_F         = pc_reg;
    assign pc4_F        = pc_reg + 32'd4;
    assign fetch_valid  = fetch_valid_reg;
    assign redirect_cnt = cnt_reg;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl with a cycle-level reference model and
// per-cycle comparison of every output.
module tb_pc_ctrl;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall_D;
    logic          is_branch_D;
    logic          br_cond_D;
    logic          is_j_D;
    logic          is_jr_D;
    logic [31:0]   npc_target_D;
    logic [31:0]   jr_target_D;
    logic          imem_ready;
    logic [31:0]   pc_F;
    logic [31:0]   pc4_F;
    logic          fetch_valid;
    logic          redirect_pending;
    logic          align_err;
    logic [CW-1:0] redirect_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_ctrl #(.RESET_PC(32'h0000_3000), .CNT_W(CW)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall_D          (stall_D),
        .is_branch_D      (is_branch_D),
        .br_cond_D        (br_cond_D),
        .is_j_D           (is_j_D),
        .is_jr_D          (is_jr_D),
        .npc_target_D     (npc_target_D),
        .jr_target_D      (jr_target_D),
        .imem_ready       (imem_ready),
        .pc_F             (pc_F),
        .pc4_F            (pc4_F),
        .fetch_valid      (fetch_valid),
        .redirect_pending (redirect_pending),
        .align_err        (align_err),
        .redirect_cnt     (redirect_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fetch pointer, boot flag, one pending redirect slot.
    logic [31:0] m_pc;
    logic        m_boot;
    logic        m_pend;
    logic [31:0] m_ptgt;
    int          m_cnt;
    logic        m_err;
    logic        live = 1'b0;

    always @(posedge clk) begin
        logic        want;
        logic        acc;
        logic [31:0] t;
        if (reset) begin
            m_pc   <= 32'h3000;
            m_boot <= 1'b1;
            m_pend <= 1'b0;
            m_ptgt <= 32'd0;
            m_cnt  <= 0;
            m_err  <= 1'b0;
            live   <= 1'b1;
        end else if (live) begin
            want = !stall_D && (is_jr_D || is_j_D || (is_branch_D && br_cond_D));
            acc  = !m_boot && imem_ready && !stall_D;
            t    = is_jr_D ? jr_target_D : npc_target_D;
            if (m_boot) begin
                m_boot <= 1'b0;
            end else if (m_pend) begin
                if (acc) begin
                    m_pc   <= m_ptgt;
                    m_pend <= 1'b0;
                end
            end else if (want) begin
                if (m_cnt < (2 ** CW) - 1)
                    m_cnt <= m_cnt + 1;
                if (t % 4 != 0)
                    m_err <= 1'b1;
                if (acc) begin
                    m_pc <= t - (t % 4);
                end else begin
                    m_pend <= 1'b1;
                    m_ptgt <= t - (t % 4);
                end
            end else if (acc) begin
                m_pc <= m_pc + 32'd4;
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("pc_F", pc_F, m_pc);
            chk("pc4_F", pc4_F, m_pc + 32'd4);
            chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, !m_boot});
            chk("redirect_pending", {31'd0, redirect_pending}, {31'd0, m_pend});
            chk("align_err", {31'd0, align_err}, {31'd0, m_err});
            chk("redirect_cnt", {24'd0, redirect_cnt}, m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        $display("t=%0t pc=%h fv=%b pend=%b cnt=%0d err=%b", $time, pc_F, fetch_valid,
                 redirect_pending, redirect_cnt, align_err);
    endtask

    task automatic clr();
        stall_D      = 1'b0;
        is_branch_D  = 1'b0;
        br_cond_D    = 1'b0;
        is_j_D       = 1'b0;
        is_jr_D      = 1'b0;
        npc_target_D = 32'd0;
        jr_target_D  = 32'd0;
    endtask

    initial begin
        reset = 1'b1;
        clr();
        imem_ready = 1'b1;
        tick();
        tick();
        chk("rst_pc", pc_F, 32'h3000);
        chk("rst_fv", {31'd0, fetch_valid}, 32'd0);
        chk("rst_cnt", {24'd0, redirect_cnt}, 32'd0);

        // Sequential fetch after BOOT
        reset = 1'b0;
        tick();
        chk("boot_pc", pc_F, 32'h3000);
        chk("run_fv", {31'd0, fetch_valid}, 32'd1);
        tick();
        chk("seq1", pc_F, 32'h3004);
        tick();
        chk("seq2", pc_F, 32'h3008);

        // Taken then not-taken branch
        is_branch_D = 1'b1; br_cond_D = 1'b1; npc_target_D = 32'h3040;
        tick();
        chk("br_taken", pc_F, 32'h3040);
        chk("br_cnt", {24'd0, redirect_cnt}, 32'd1);
        br_cond_D = 1'b0;
        tick();
        chk("br_not_taken", pc_F, 32'h3044);
        clr();

        // jr under back-pressure; a jump during HOLD must be ignored
        is_jr_D = 1'b1; jr_target_D = 32'h3100; imem_ready = 1'b0;
        tick();
        chk("jr_pend", {31'd0, redirect_pending}, 32'd1);
        chk("jr_hold_pc", pc_F, 32'h3044);
        clr();
        is_j_D = 1'b1; npc_target_D = 32'h5000;
        tick();
        tick();
        chk("hold_pc", pc_F, 32'h3044);
        chk("hold_cnt", {24'd0, redirect_cnt}, 32'd2);
        clr();
        imem_ready = 1'b1;
        tick();
        chk("jr_release", pc_F, 32'h3100);
        chk("jr_pend_clr", {31'd0, redirect_pending}, 32'd0);

        // Stalled jump is not taken until the stall drops
        stall_D = 1'b1; is_j_D = 1'b1; npc_target_D = 32'h3300;
        tick();
        tick();
        chk("stall_pc", pc_F, 32'h3100);
        chk("stall_cnt", {24'd0, redirect_cnt}, 32'd2);
        stall_D = 1'b0;
        tick();
        chk("j_after_stall", pc_F, 32'h3300);
        clr();

        // jr beats j; misaligned target fixed up and flagged
        is_jr_D = 1'b1; is_j_D = 1'b1; jr_target_D = 32'h3202; npc_target_D = 32'h4000;
        tick();
        chk("align_pc", pc_F, 32'h3200);
        chk("align_err", {31'd0, align_err}, 32'd1);
        clr();
        tick();
        tick();
        chk("align_sticky", {31'd0, align_err}, 32'd1);
        chk("align_seq", pc_F, 32'h3208);

        // pc+4 wraps
        is_j_D = 1'b1; npc_target_D = 32'hFFFF_FFFC;
        tick();
        clr();
        tick();
        chk("wrap_pc", pc_F, 32'h0000_0000);

        // Counter saturation
        is_j_D = 1'b1; npc_target_D = 32'h3000;
        for (int i = 0; i < 260; i++) begin
            @(posedge clk);
            #1;
        end
        chk("cnt_sat", {24'd0, redirect_cnt}, 32'h0000_00FF);
        clr();

        // Reset while HOLD drops the pending target
        is_j_D = 1'b1; npc_target_D = 32'h3500; imem_ready = 1'b0;
        tick();
        chk("pre_rst_pend", {31'd0, redirect_pending}, 32'd1);
        reset = 1'b1;
        tick();
        chk("hrst_pc", pc_F, 32'h3000);
        chk("hrst_cnt", {24'd0, redirect_cnt}, 32'd0);
        chk("hrst_err", {31'd0, align_err}, 32'd0);
        reset = 1'b0;
        clr();
        imem_ready = 1'b1;
        tick();
        chk("hrst_boot_pc", pc_F, 32'h3000);
        tick();
        chk("hrst_seq", pc_F, 32'h3004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
